// File: rtl/fifo_pkg.sv
// Shared constants and buffer-state encoding for the
// async_fifo read-side drain path.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry head/tail skid register pair; head is
// always the oldest word, tail only used when full.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            cnt,
  output logic                  valid
);

  buf_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (push) begin
          head_d  = din;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (push && pop) begin
          head_d = din;
        end else if (push) begin
          tail_d  = din;
          state_d = BUF_TWO;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        // credit logic never pushes while full
        if (pop) begin
          head_d  = tail_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  assign head  = head_q;
  assign cnt   = state_q;
  assign valid = (state_q != BUF_EMPTY);

endmodule

// File: rtl/fifo_rd_stream.sv
// async_fifo read drain to valid/ready stream with packet tagging.
// Optional counters: define FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PKT_LEN    = 8
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]           beat_cnt,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int CNT_W = $clog2(PKT_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

  logic             inflight_q;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic [1:0]       cnt;
  logic             pop;
  logic             is_last;
  logic [2:0]       used;
  logic [2:0]       room;

  assign pop = m_valid && m_ready;

  // credit = room - used; a read is allowed while it stays positive
  assign used  = {1'b0, cnt} + {2'b0, inflight_q};
  assign room  = 3'(SKID_DEPTH) + {2'b0, pop};
  assign rd_en = rst_n && !empty && (room > used);

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;
    end
  end

  fifo_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk   (rd_clk),
    .rst_n (rst_n),
    .push  (inflight_q),
    .din   (dout),
    .pop   (pop),
    .head  (m_data),
    .cnt   (cnt),
    .valid (m_valid)
  );

  assign is_last = (pkt_cnt_q == LAST_IDX);
  assign m_last  = m_valid && is_last;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= '0;
    end else if (pop) begin
      pkt_cnt_q <= is_last ? '0 : pkt_cnt_q + 1'b1;
    end
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop) begin
        beat_cnt <= beat_cnt + 32'd1;
      end
      if (m_valid && !m_ready && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
